alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit ALU between two requesters. It accepts an operation (a, b, op) from either requester through a valid/ready handshake and drives the operands onto the registered ALU input ports. It captures the ALU's combinational 8-bit result and returns it, tagged with the requester ID, through a valid/ready response port. The ALU is instantiated outside this block, next to it at the same level of hierarchy.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
//
// Operations (a, b, op) are accepted from requester 0 or 1 through a
// valid/ready handshake, with round-robin choice on a tie. The operands are
// registered onto the ALU input ports. The ALU's combinational result is
// captured one cycle later and returned, tagged with the requester ID,
// through a valid/ready response port.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op    request operands and opcode
//   alu_a, alu_b, alu_op       registered operands driven to the ALU
//   alu_res                    combinational result returned by the ALU
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_res            requester ID and captured ALU result
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no operation in flight; grants any valid request
// EXEC   | operands on ALU ports; ALU result settles this cycle
// RESP   | response held; a new request is granted on the handshake cycle

module alu_arbiter #(
  parameter int DW  = 4,
  parameter int OPW = 3,
  parameter int RW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,

  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [RW-1:0]  alu_res,

  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [RW-1:0]  rsp_res
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last_grant;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic           r_rsp_valid;
  logic           r_rsp_id;
  logic [RW-1:0]  r_rsp_res;

  logic           w_can_grant;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_rsp_hs;

  // In RESP rsp_valid is always high, so rsp_ready alone marks the handshake.
  assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready;
  assign w_can_grant = (r_state == S_IDLE) || w_rsp_hs;

  // On a tie the requester that did not win last time is granted; the two
  // terms are mutually exclusive by construction.
  assign w_gnt0 = w_can_grant && req0_valid && (!req1_valid ||  r_last_grant);
  assign w_gnt1 = w_can_grant && req1_valid && (!req0_valid || !r_last_grant);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt0 || w_gnt1) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = (w_gnt0 || w_gnt1) ? S_EXEC : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_res    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_gnt0) begin
        r_alu_a      <= req0_a;
        r_alu_b      <= req0_b;
        r_alu_op     <= req0_op;
        r_rsp_id     <= 1'b0;
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_alu_a      <= req1_a;
        r_alu_b      <= req1_b;
        r_alu_op     <= req1_op;
        r_rsp_id     <= 1'b1;
        r_last_grant <= 1'b1;
      end

      if (r_state == S_EXEC) begin
        r_rsp_res   <= alu_res;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_res    = r_rsp_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU beside the DUT and a
// scoreboard of expected responses pushed at each grant.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_res;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [7:0] ea, eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      3'd0:    return ea + eb;
      3'd1:    return ea * eb;
      3'd2:    return ea - eb;
      3'd3:    return ea & eb;
      default: return ea ^ eb;
    endcase
  endfunction

  assign alu_res = alu_model(alu_a, alu_b, alu_op);

  alu_arbiter #(.DW(4), .OPW(3), .RW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on each grant, pop on each response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot", 32'(req0_ready & req1_ready), 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(mon_e.id));
          check("sb_res", 32'(rsp_res), 32'(mon_e.res));
        end
      end
      if (req0_ready) begin
        check("ready0_needs_valid", 32'(req0_valid), 1);
        mon_e.id  = 1'b0;
        mon_e.res = alu_model(req0_a, req0_b, req0_op);
        sb.push_back(mon_e);
      end
      if (req1_ready) begin
        check("ready1_needs_valid", 32'(req1_valid), 1);
        mon_e.id  = 1'b1;
        mon_e.res = alu_model(req1_a, req1_b, req1_op);
        sb.push_back(mon_e);
      end
    end
  end

  initial begin
    logic exp_g;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_res", 32'(rsp_res), 0);
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    rst_n = 1'b1;

    // Single request: 2 + 3
    cyc();
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_op = 3'd0;
    rsp_ready = 1'b1;
    #1;
    check("single_ready0", 32'(req0_ready), 1);
    check("single_ready1", 32'(req1_ready), 0);
    cyc();
    req0_valid = 1'b0;
    #1;
    check("single_alu_a", 32'(alu_a), 2);
    check("single_alu_b", 32'(alu_b), 3);
    check("single_alu_op", 32'(alu_op), 0);
    check("single_exec_valid", 32'(rsp_valid), 0);
    check("single_exec_ready0", 32'(req0_ready), 0);
    cyc();
    check("single_rsp_valid", 32'(rsp_valid), 1);
    check("single_rsp_id", 32'(rsp_id), 0);
    check("single_rsp_res", 32'(rsp_res), 5);
    cyc();
    check("single_drained", 32'(rsp_valid), 0);

    // Contention: requester 0 won last, so the alternation starts at 1
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd4; req0_op = 3'd1;
    req1_valid = 1'b1; req1_a = 4'd10; req1_b = 4'd9; req1_op = 3'd0;
    exp_g = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_grant0", 32'(req0_ready), 32'(!exp_g));
      check("cont_grant1", 32'(req1_ready), 32'(exp_g));
      cyc();
      check("cont_exec_ready", 32'(req0_ready | req1_ready), 0);
      check("cont_exec_valid", 32'(rsp_valid), 0);
      cyc();
      check("cont_rsp_valid", 32'(rsp_valid), 1);
      check("cont_rsp_id", 32'(rsp_id), 32'(exp_g));
      check("cont_rsp_res", 32'(rsp_res), exp_g ? 19 : 12);
      exp_g = !exp_g;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("cont_end_ready", 32'(req0_ready | req1_ready), 0);
    cyc();
    check("cont_end_idle", 32'(rsp_valid), 0);

    // Backpressure: 15 * 15 held while rsp_ready is low
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15; req1_op = 3'd1;
    #1;
    check("bp_grant1", 32'(req1_ready), 1);
    cyc();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2; req0_op = 3'd2;
    #1;
    check("bp_exec_ready", 32'(req0_ready | req1_ready), 0);
    cyc();
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    check("bp_rsp_id", 32'(rsp_id), 1);
    check("bp_rsp_res", 32'(rsp_res), 225);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_res", 32'(rsp_res), 225);
      check("bp_hold_ready", 32'(req0_ready | req1_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_drain_grant0", 32'(req0_ready), 1);
    check("bp_drain_grant1", 32'(req1_ready), 0);
    cyc();
    req0_valid = 1'b0;
    check("bp_next_alu_a", 32'(alu_a), 7);
    check("bp_next_alu_op", 32'(alu_op), 2);
    check("bp_next_exec_valid", 32'(rsp_valid), 0);
    cyc();
    check("bp_next_rsp_valid", 32'(rsp_valid), 1);
    check("bp_next_rsp_id", 32'(rsp_id), 0);
    check("bp_next_rsp_res", 32'(rsp_res), 5);

    // Reset during EXEC discards the operation
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = 3'd0;
    #1;
    check("rm_grant1", 32'(req1_ready), 1);
    cyc();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rm_rsp_valid", 32'(rsp_valid), 0);
    check("rm_alu_a", 32'(alu_a), 0);
    check("rm_alu_b", 32'(alu_b), 0);
    check("rm_alu_op", 32'(alu_op), 0);
    check("rm_rsp_res", 32'(rsp_res), 0);
    check("rm_rsp_id", 32'(rsp_id), 0);
    cyc();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd4; req0_op = 3'd1;
    req1_valid = 1'b1; req1_a = 4'd10; req1_b = 4'd9; req1_op = 3'd0;
    #1;
    check("rm_tie_grant0", 32'(req0_ready), 1);
    check("rm_tie_grant1", 32'(req1_ready), 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    check("rm_rsp_valid_after", 32'(rsp_valid), 1);
    check("rm_rsp_id_after", 32'(rsp_id), 0);
    check("rm_rsp_res_after", 32'(rsp_res), 12);
    cyc();
    check("rm_idle", 32'(rsp_valid), 0);

    // Withdrawn request while backpressured
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6; req0_op = 3'd3;
    #1;
    check("wd_grant0", 32'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd9; req1_op = 3'd0;
    #1;
    check("wd_blocked1", 32'(req1_ready), 0);
    cyc();
    check("wd_blocked1_again", 32'(req1_ready), 0);
    check("wd_rsp_valid", 32'(rsp_valid), 1);
    check("wd_rsp_res", 32'(rsp_res), 4);
    req1_valid = 1'b0;
    cyc();
    rsp_ready = 1'b1;
    #1;
    check("wd_drain_ready", 32'(req0_ready | req1_ready), 0);
    cyc();
    check("wd_drained", 32'(rsp_valid), 0);
    cyc();
    cyc();
    check("wd_idle_valid", 32'(rsp_valid), 0);
    check("wd_idle_ready", 32'(req0_ready | req1_ready), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
